// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: round-robin arbiter and sequencer between two single-word
// requesters (A = processor MEM stage, B = loader/debug) and a DEPTH_WORDS x
// DATA_WIDTH data memory. Each accepted command runs as one memory access.
// Illegal addresses (misaligned or out of range) complete with Err and no access.
//
// Ports:
//   Clock, Reset_n                 clock, async active-low reset
//   {A,B}_Req/_Write/_Addr/_WData  requester command, held until Gnt
//   {A,B}_Gnt                      one-cycle pulse: command accepted
//   {A,B}_Done/_Err/_RData         completion pulse, error flag, read data (held)
//   MemRead/MemWrite               memory strobes, high for one ACCESS cycle
//   ReadAddress/WriteAddress       memory byte address (always identical)
//   WriteData, ReadData            memory write/read data
module data_mem_arbiter #(
  parameter int unsigned DEPTH_WORDS = 32,
  parameter int unsigned DATA_WIDTH  = 32
) (
  input  logic                  Clock,
  input  logic                  Reset_n,
  input  logic                  A_Req,
  input  logic                  A_Write,
  input  logic [31:0]           A_Addr,
  input  logic [DATA_WIDTH-1:0] A_WData,
  input  logic                  B_Req,
  input  logic                  B_Write,
  input  logic [31:0]           B_Addr,
  input  logic [DATA_WIDTH-1:0] B_WData,
  output logic                  A_Gnt,
  output logic                  A_Done,
  output logic                  A_Err,
  output logic [DATA_WIDTH-1:0] A_RData,
  output logic                  B_Gnt,
  output logic                  B_Done,
  output logic                  B_Err,
  output logic [DATA_WIDTH-1:0] B_RData,
  output logic                  MemRead,
  output logic                  MemWrite,
  output logic [31:0]           ReadAddress,
  output logic [31:0]           WriteAddress,
  output logic [DATA_WIDTH-1:0] WriteData,
  input  logic [DATA_WIDTH-1:0] ReadData
);

  localparam int unsigned    AW         = 32;
  localparam logic [AW-1:0]  ADDR_LIMIT = AW'(4 * DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t                state, state_nxt;
  logic                  last_b, last_b_nxt;     // 1: B was served last
  logic                  sel_b, sel_b_nxt;       // owner of the in-flight op
  logic                  op_write, op_write_nxt;
  logic                  op_err, op_err_nxt;

  logic                  a_gnt_nxt, b_gnt_nxt, a_done_nxt, b_done_nxt;
  logic                  a_err_nxt, b_err_nxt, mem_read_nxt, mem_write_nxt;
  logic [DATA_WIDTH-1:0] a_rdata_nxt, b_rdata_nxt, wdata_nxt;
  logic [AW-1:0]         addr_nxt;

  // Winner selection and command mux for the current IDLE sample
  logic                  pick_b;
  logic                  cmd_write;
  logic [AW-1:0]         cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_wdata;
  logic                  cmd_legal;

  always_comb begin
    pick_b    = B_Req && (!A_Req || !last_b);
    cmd_write = pick_b ? B_Write : A_Write;
    cmd_addr  = pick_b ? B_Addr  : A_Addr;
    cmd_wdata = pick_b ? B_WData : A_WData;
    cmd_legal = (cmd_addr[1:0] == 2'b00) && (cmd_addr < ADDR_LIMIT);
  end

  // Next-state and next-output logic
  always_comb begin
    state_nxt     = state;
    last_b_nxt    = last_b;
    sel_b_nxt     = sel_b;
    op_write_nxt  = op_write;
    op_err_nxt    = op_err;
    a_gnt_nxt     = 1'b0;
    b_gnt_nxt     = 1'b0;
    a_done_nxt    = 1'b0;
    b_done_nxt    = 1'b0;
    a_err_nxt     = 1'b0;
    b_err_nxt     = 1'b0;
    mem_read_nxt  = 1'b0;
    mem_write_nxt = 1'b0;
    a_rdata_nxt   = A_RData;
    b_rdata_nxt   = B_RData;
    addr_nxt      = ReadAddress;
    wdata_nxt     = WriteData;

    case (state)
      IDLE: begin
        if (A_Req || B_Req) begin
          a_gnt_nxt    = !pick_b;
          b_gnt_nxt    = pick_b;
          last_b_nxt   = pick_b;
          sel_b_nxt    = pick_b;
          op_write_nxt = cmd_write;
          op_err_nxt   = !cmd_legal;
          if (cmd_legal) begin
            addr_nxt      = cmd_addr;
            wdata_nxt     = cmd_wdata;
            mem_read_nxt  = !cmd_write;
            mem_write_nxt = cmd_write;
            state_nxt     = ACCESS;
          end else begin
            state_nxt     = RESP;
          end
        end
      end
      ACCESS: begin
        // Memory samples the strobe on this edge; strobes fall via defaults
        state_nxt = RESP;
      end
      RESP: begin
        a_done_nxt = !sel_b;
        b_done_nxt = sel_b;
        if (op_err) begin
          a_err_nxt = !sel_b;
          b_err_nxt = sel_b;
          if (sel_b) b_rdata_nxt = '0;
          else       a_rdata_nxt = '0;
        end else if (!op_write) begin
          if (sel_b) b_rdata_nxt = ReadData;
          else       a_rdata_nxt = ReadData;
        end
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and registered outputs
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state        <= IDLE;
      last_b       <= 1'b1;
      sel_b        <= 1'b0;
      op_write     <= 1'b0;
      op_err       <= 1'b0;
      A_Gnt        <= 1'b0;
      B_Gnt        <= 1'b0;
      A_Done       <= 1'b0;
      B_Done       <= 1'b0;
      A_Err        <= 1'b0;
      B_Err        <= 1'b0;
      A_RData      <= '0;
      B_RData      <= '0;
      MemRead      <= 1'b0;
      MemWrite     <= 1'b0;
      ReadAddress  <= '0;
      WriteAddress <= '0;
      WriteData    <= '0;
    end else begin
      state        <= state_nxt;
      last_b       <= last_b_nxt;
      sel_b        <= sel_b_nxt;
      op_write     <= op_write_nxt;
      op_err       <= op_err_nxt;
      A_Gnt        <= a_gnt_nxt;
      B_Gnt        <= b_gnt_nxt;
      A_Done       <= a_done_nxt;
      B_Done       <= b_done_nxt;
      A_Err        <= a_err_nxt;
      B_Err        <= b_err_nxt;
      A_RData      <= a_rdata_nxt;
      B_RData      <= b_rdata_nxt;
      MemRead      <= mem_read_nxt;
      MemWrite     <= mem_write_nxt;
      ReadAddress  <= addr_nxt;
      WriteAddress <= addr_nxt;
      WriteData    <= wdata_nxt;
    end
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb_data_mem_arbiter: self-checking bench for data_mem_arbiter with a
// behavioural memory, directed scenarios and a transaction-level random model.
module tb_data_mem_arbiter;

  logic        Clock = 1'b0;
  logic        Reset_n;
  logic        A_Req, A_Write, B_Req, B_Write;
  logic [31:0] A_Addr, A_WData, B_Addr, B_WData;
  logic        A_Gnt, A_Done, A_Err, B_Gnt, B_Done, B_Err;
  logic [31:0] A_RData, B_RData;
  logic        MemRead, MemWrite;
  logic [31:0] ReadAddress, WriteAddress, WriteData;
  logic [31:0] ReadData = 32'd0;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [32];
  logic        mem_loaded = 1'b0;
  logic [31:0] shadow [32];

  always #5 Clock = ~Clock;

  data_mem_arbiter dut (
    .Clock(Clock), .Reset_n(Reset_n),
    .A_Req(A_Req), .A_Write(A_Write), .A_Addr(A_Addr), .A_WData(A_WData),
    .B_Req(B_Req), .B_Write(B_Write), .B_Addr(B_Addr), .B_WData(B_WData),
    .A_Gnt(A_Gnt), .A_Done(A_Done), .A_Err(A_Err), .A_RData(A_RData),
    .B_Gnt(B_Gnt), .B_Done(B_Done), .B_Err(B_Err), .B_RData(B_RData),
    .MemRead(MemRead), .MemWrite(MemWrite),
    .ReadAddress(ReadAddress), .WriteAddress(WriteAddress),
    .WriteData(WriteData), .ReadData(ReadData)
  );

  function automatic logic [31:0] init_word(input int i);
    return (i == 1) ? 32'd84 : 32'h1000_0000 + 32'(i * 37);
  endfunction

  // Data memory: registers ReadData when it samples MemRead
  always @(posedge Clock) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 32; i++) mem[i] <= init_word(i);
      mem_loaded <= 1'b1;
    end else begin
      if (MemWrite) mem[WriteAddress[6:2]] <= WriteData;
      if (MemRead)  ReadData <= mem[ReadAddress[6:2]];
    end
  end

  function automatic logic [31:0] rand_addr(input bit legal_only);
    logic [31:0] a;
    int sel;
    sel = legal_only ? 9 : int'($urandom_range(0, 9));
    case (sel)
      0:       a = 32'($urandom_range(0, 31) * 4 + $urandom_range(1, 3));
      1:       a = 32'(128 + $urandom_range(0, 4000));
      2:       a = $urandom;
      default: a = 32'($urandom_range(0, 31) * 4);
    endcase
    return a;
  endfunction

  task automatic apply_reset();
    @(negedge Clock);
    Reset_n = 1'b0;
    A_Req = 1'b0;
    B_Req = 1'b0;
    @(negedge Clock);
    @(negedge Clock);
    Reset_n = 1'b1;
  endtask

  // Drives one transaction on one port and records what the DUT did
  task automatic run_txn(input bit port_b, input bit wr, input logic [31:0] addr,
                         input logic [31:0] wd, output int gnt_k, output int gnt_cnt,
                         output int done_k, output logic err, output logic [31:0] rd,
                         output int rd_pulses, output int wr_pulses,
                         output logic [31:0] strobe_addr, output int other_evt);
    gnt_k = -1; gnt_cnt = 0; done_k = -1; err = 1'b0; rd = '0;
    rd_pulses = 0; wr_pulses = 0; strobe_addr = '0; other_evt = 0;
    if (port_b) begin B_Req = 1'b1; B_Write = wr; B_Addr = addr; B_WData = wd; end
    else        begin A_Req = 1'b1; A_Write = wr; A_Addr = addr; A_WData = wd; end
    for (int k = 1; k <= 12 && done_k < 0; k++) begin
      @(negedge Clock);
      if (MemRead)  begin rd_pulses++; strobe_addr = ReadAddress; end
      if (MemWrite) begin wr_pulses++; strobe_addr = WriteAddress; end
      if (MemRead && MemWrite) other_evt++;
      if (port_b ? (A_Gnt || A_Done) : (B_Gnt || B_Done)) other_evt++;
      if (port_b ? B_Gnt : A_Gnt) begin
        gnt_cnt++;
        if (gnt_k < 0) gnt_k = k;
        A_Req = 1'b0;
        B_Req = 1'b0;
      end
      if (port_b ? B_Done : A_Done) begin
        done_k = k;
        err = port_b ? B_Err : A_Err;
        rd  = port_b ? B_RData : A_RData;
      end
    end
    A_Req = 1'b0;
    B_Req = 1'b0;
  endtask

  task automatic test_reset();
    A_Req = 1'b1; B_Req = 1'b1; A_Write = 1'b0; B_Write = 1'b1;
    A_Addr = 32'd4; B_Addr = 32'd8; A_WData = 32'd1; B_WData = 32'd2;
    for (int k = 0; k < 4; k++) begin
      @(negedge Clock);
      checks++;
      if ({A_Gnt, B_Gnt, A_Done, B_Done, A_Err, B_Err, MemRead, MemWrite} !== 8'h00) begin
        errors++;
        $display("FAIL reset_ctrl: got %b required 00000000",
                 {A_Gnt, B_Gnt, A_Done, B_Done, A_Err, B_Err, MemRead, MemWrite});
      end
      checks++;
      if ((A_RData | B_RData | ReadAddress | WriteAddress | WriteData) !== 32'd0) begin
        errors++;
        $display("FAIL reset_data: got %h/%h/%h/%h/%h required all 0",
                 A_RData, B_RData, ReadAddress, WriteAddress, WriteData);
      end
    end
    A_Req = 1'b0; B_Req = 1'b0;
    @(negedge Clock);
    Reset_n = 1'b1;
    @(negedge Clock);
  endtask

  task automatic test_read_a();
    int gk, gc, dk, rp, wp, oe; logic e; logic [31:0] rd, sa;
    run_txn(1'b0, 1'b0, 32'd4, 32'd0, gk, gc, dk, e, rd, rp, wp, sa, oe);
    checks++; if (gk !== 1 || gc !== 1) begin errors++; $display("FAIL read_a_gnt: got k=%0d cnt=%0d required k=1 cnt=1", gk, gc); end
    checks++; if (dk !== 3) begin errors++; $display("FAIL read_a_latency: got %0d required 3", dk); end
    checks++; if (rp !== 1 || wp !== 0 || sa !== 32'd4) begin errors++; $display("FAIL read_a_strobe: got rd=%0d wr=%0d addr=%0d required 1 0 4", rp, wp, sa); end
    checks++; if (rd !== 32'd84 || e !== 1'b0) begin errors++; $display("FAIL read_a_data: got %0d err=%b required 84 err=0", rd, e); end
    checks++; if (oe !== 0) begin errors++; $display("FAIL read_a_other: got %0d required 0", oe); end
  endtask

  task automatic test_write_read();
    int gk, gc, dk, rp, wp, oe; logic e; logic [31:0] rd, sa;
    run_txn(1'b1, 1'b1, 32'd12, 32'hDEADBEEF, gk, gc, dk, e, rd, rp, wp, sa, oe);
    shadow[3] = 32'hDEADBEEF;
    checks++; if (wp !== 1 || rp !== 0 || sa !== 32'd12) begin errors++; $display("FAIL write_b_strobe: got wr=%0d rd=%0d addr=%0d required 1 0 12", wp, rp, sa); end
    checks++; if (dk !== 3 || e !== 1'b0) begin errors++; $display("FAIL write_b_done: got k=%0d err=%b required k=3 err=0", dk, e); end
    run_txn(1'b0, 1'b0, 32'd12, 32'd0, gk, gc, dk, e, rd, rp, wp, sa, oe);
    checks++; if (rd !== 32'hDEADBEEF || dk !== 3) begin errors++; $display("FAIL write_read_data: got %h k=%0d required deadbeef k=3", rd, dk); end
  endtask

  task automatic test_illegal();
    int gk, gc, dk, rp, wp, oe; logic e; logic [31:0] rd, sa;
    logic [31:0] bad [2];
    bad[0] = 32'd6;
    bad[1] = 32'd128;
    for (int i = 0; i < 2; i++) begin
      run_txn(1'b0, 1'b0, bad[i], 32'd0, gk, gc, dk, e, rd, rp, wp, sa, oe);
      checks++; if (gk !== 1 || dk !== 2) begin errors++; $display("FAIL illegal_timing[%0d]: got gnt=%0d done=%0d required 1 2", i, gk, dk); end
      checks++; if (e !== 1'b1 || rd !== 32'd0) begin errors++; $display("FAIL illegal_resp[%0d]: got err=%b rdata=%h required 1 0", i, e, rd); end
      checks++; if (rp !== 0 || wp !== 0) begin errors++; $display("FAIL illegal_strobe[%0d]: got rd=%0d wr=%0d required 0 0", i, rp, wp); end
    end
  endtask

  task automatic test_contention();
    int ngr, last_k, exp_k;
    bit exp_b;
    apply_reset();
    A_Write = 1'($urandom_range(0, 1)); A_Addr = rand_addr(1'b1); A_WData = $urandom;
    B_Write = 1'($urandom_range(0, 1)); B_Addr = rand_addr(1'b1); B_WData = $urandom;
    A_Req = 1'b1; B_Req = 1'b1;
    ngr = 0; last_k = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge Clock);
      checks++;
      if (MemRead && MemWrite) begin errors++; $display("FAIL cont_strobes: got both high at cycle %0d required exclusive", k); end
      if (A_Gnt || B_Gnt) begin
        exp_b = (ngr % 2) == 1;
        exp_k = (ngr == 0) ? 1 : last_k + 3;
        checks++;
        if (A_Gnt === B_Gnt || B_Gnt !== exp_b) begin
          errors++; $display("FAIL cont_order: grant %0d got A=%b B=%b required B=%b", ngr, A_Gnt, B_Gnt, exp_b);
        end
        checks++;
        if (k != exp_k) begin errors++; $display("FAIL cont_spacing: grant %0d got cycle %0d required %0d", ngr, k, exp_k); end
        if (A_Gnt) begin
          if (A_Write) shadow[A_Addr[6:2]] = A_WData;
          A_Write = 1'($urandom_range(0, 1)); A_Addr = rand_addr(1'b1); A_WData = $urandom;
        end else begin
          if (B_Write) shadow[B_Addr[6:2]] = B_WData;
          B_Write = 1'($urandom_range(0, 1)); B_Addr = rand_addr(1'b1); B_WData = $urandom;
        end
        last_k = k;
        ngr++;
      end
    end
    checks++;
    if (ngr != 14) begin errors++; $display("FAIL cont_count: got %0d grants required 14", ngr); end
    A_Req = 1'b0; B_Req = 1'b0;
    repeat (4) @(negedge Clock);
  endtask

  // Random traffic checked against a transaction-level model
  task automatic test_random();
    bit free, last_b, win_b, fly_b, fly_wr, fly_legal;
    bit eg_a, eg_b, ed_a, ed_b, emr, emw;
    logic [31:0] fly_addr, fly_wd, fly_exp, held_a, held_b;
    int done_at;
    apply_reset();
    free = 1'b1; last_b = 1'b1; held_a = '0; held_b = '0; done_at = -1;
    fly_b = 1'b0; fly_wr = 1'b0; fly_legal = 1'b0; fly_addr = '0; fly_wd = '0; fly_exp = '0;
    A_Req = 1'b0; B_Req = 1'b0;
    for (int k = 1; k <= 400; k++) begin
      @(negedge Clock);
      eg_a = 0; eg_b = 0; ed_a = 0; ed_b = 0; emr = 0; emw = 0;
      if (free && (A_Req || B_Req)) begin
        win_b = (A_Req && B_Req) ? !last_b : B_Req;
        last_b = win_b; free = 1'b0; fly_b = win_b;
        fly_wr   = win_b ? B_Write : A_Write;
        fly_addr = win_b ? B_Addr  : A_Addr;
        fly_wd   = win_b ? B_WData : A_WData;
        fly_legal = (fly_addr % 4 == 0) && (fly_addr < 32'd128);
        done_at = k + (fly_legal ? 2 : 1);
        eg_a = !win_b; eg_b = win_b;
        fly_exp = '0;
        if (fly_legal) begin
          emr = !fly_wr; emw = fly_wr;
          if (fly_wr) shadow[fly_addr[6:2]] = fly_wd;
          else        fly_exp = shadow[fly_addr[6:2]];
        end
      end else if (!free && k == done_at) begin
        ed_a = !fly_b; ed_b = fly_b;
      end
      checks++;
      if ({A_Gnt, B_Gnt} !== {eg_a, eg_b}) begin errors++; $display("FAIL rnd_gnt @%0d: got %b%b required %b%b", k, A_Gnt, B_Gnt, eg_a, eg_b); end
      checks++;
      if ({A_Done, B_Done} !== {ed_a, ed_b}) begin errors++; $display("FAIL rnd_done @%0d: got %b%b required %b%b", k, A_Done, B_Done, ed_a, ed_b); end
      checks++;
      if ({MemRead, MemWrite} !== {emr, emw}) begin errors++; $display("FAIL rnd_strobe @%0d: got %b%b required %b%b", k, MemRead, MemWrite, emr, emw); end
      if (emr || emw) begin
        checks++;
        if (ReadAddress !== fly_addr || WriteAddress !== fly_addr || (emw && WriteData !== fly_wd)) begin
          errors++; $display("FAIL rnd_memcmd @%0d: got ra=%h wa=%h wd=%h required a=%h wd=%h", k, ReadAddress, WriteAddress, WriteData, fly_addr, fly_wd);
        end
      end
      if (ed_a || ed_b) begin
        if (!fly_legal || !fly_wr) begin
          if (fly_b) held_b = fly_exp; else held_a = fly_exp;
        end
        checks++;
        if ({A_Err, B_Err} !== {ed_a && !fly_legal, ed_b && !fly_legal}) begin
          errors++; $display("FAIL rnd_err @%0d: got %b%b required legal=%b", k, A_Err, B_Err, fly_legal);
        end
        free = 1'b1;
      end else begin
        checks++;
        if ({A_Err, B_Err} !== 2'b00) begin errors++; $display("FAIL rnd_err_idle @%0d: got %b%b required 00", k, A_Err, B_Err); end
      end
      checks++;
      if (A_RData !== held_a || B_RData !== held_b) begin
        errors++; $display("FAIL rnd_rdata @%0d: got %h/%h required %h/%h", k, A_RData, B_RData, held_a, held_b);
      end
      if ((A_Req && A_Gnt) || !A_Req) begin
        A_Req = A_Req ? ($urandom_range(0, 3) != 0) : 1'($urandom_range(0, 1));
        A_Write = 1'($urandom_range(0, 1)); A_Addr = rand_addr(1'b0); A_WData = $urandom;
      end
      if ((B_Req && B_Gnt) || !B_Req) begin
        B_Req = B_Req ? ($urandom_range(0, 3) != 0) : 1'($urandom_range(0, 1));
        B_Write = 1'($urandom_range(0, 1)); B_Addr = rand_addr(1'b0); B_WData = $urandom;
      end
    end
    A_Req = 1'b0; B_Req = 1'b0;
    repeat (4) @(negedge Clock);
  endtask

  task automatic test_mid_reset();
    int gk, gc, dk, rp, wp, oe; logic e; logic [31:0] rd, sa;
    B_Req = 1'b1; B_Write = 1'b1; B_Addr = 32'd20; B_WData = 32'hCAFEF00D;
    @(negedge Clock);
    checks++;
    if (B_Gnt !== 1'b1 || MemWrite !== 1'b1) begin errors++; $display("FAIL midrst_setup: got gnt=%b mw=%b required 1 1", B_Gnt, MemWrite); end
    Reset_n = 1'b0;
    B_Req = 1'b0;
    #1;
    checks++;
    if ({MemWrite, B_Gnt, B_Done} !== 3'b000) begin errors++; $display("FAIL midrst_clear: got %b required 000", {MemWrite, B_Gnt, B_Done}); end
    @(negedge Clock);
    @(negedge Clock);
    Reset_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge Clock);
      checks++;
      if (B_Done !== 1'b0 || A_Done !== 1'b0) begin errors++; $display("FAIL midrst_nodone: got A=%b B=%b required 0 0", A_Done, B_Done); end
    end
    A_Req = 1'b1; B_Req = 1'b1; A_Write = 1'b0; B_Write = 1'b0; A_Addr = 32'd0; B_Addr = 32'd8;
    @(negedge Clock);
    checks++;
    if (A_Gnt !== 1'b1 || B_Gnt !== 1'b0) begin errors++; $display("FAIL midrst_tie: got A=%b B=%b required 1 0", A_Gnt, B_Gnt); end
    A_Req = 1'b0;
    for (int k = 0; k < 8 && B_Req; k++) begin
      @(negedge Clock);
      if (B_Gnt) B_Req = 1'b0;
    end
    B_Req = 1'b0;
    repeat (4) @(negedge Clock);
    run_txn(1'b0, 1'b0, 32'd20, 32'd0, gk, gc, dk, e, rd, rp, wp, sa, oe);
    checks++;
    if (rd !== shadow[5] || dk !== 3) begin errors++; $display("FAIL midrst_mem: got %h k=%0d required %h k=3", rd, dk, shadow[5]); end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) shadow[i] = init_word(i);
    Reset_n = 1'b0;
    A_Req = 1'b0; A_Write = 1'b0; A_Addr = '0; A_WData = '0;
    B_Req = 1'b0; B_Write = 1'b0; B_Addr = '0; B_WData = '0;
    test_reset();
    test_read_a();
    test_write_read();
    test_illegal();
    test_contention();
    test_random();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
